// File: rtl/solution_serializer.sv
// Frames a captured nonogram solution as a byte stream for the UART transmitter:
// header, dimensions, bit-packed rows (MSB = lowest column), optional XOR checksum.
module solution_serializer #(
    parameter int unsigned MAX_ROWS    = 16,
    parameter int unsigned MAX_COLS    = 16,
    parameter int unsigned DIM_W       = 5,
    parameter logic [7:0]  HEADER      = 8'hE0,
    parameter bit          CHECKSUM_EN = 1'b1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               valid_in,
    input  logic [MAX_ROWS-1:0][MAX_COLS-1:0]  solution,
    input  logic [DIM_W-1:0]                   n,
    input  logic [DIM_W-1:0]                   m,
    input  logic                               transmit_busy,
    output logic                               transmit_ready,
    output logic [7:0]                         byte_out,
    output logic                               busy,
    output logic                               done,
    output logic                               error
);

    localparam int unsigned RW    = $clog2(MAX_ROWS + 1);
    localparam int unsigned BMAX  = (MAX_COLS + 7) / 8;
    localparam int unsigned BW    = $clog2(BMAX + 1);
    localparam int unsigned CNT_W = $clog2(4 + MAX_ROWS * BMAX + 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StLoad  = 3'd1;
    localparam logic [2:0] StSend  = 3'd2;
    localparam logic [2:0] StGuard = 3'd3;
    localparam logic [2:0] StWait  = 3'd4;
    localparam logic [2:0] StFin   = 3'd5;

    logic [2:0]                        state_q, state_d;
    logic [MAX_ROWS-1:0][MAX_COLS-1:0] sol_q, sol_d;
    logic [DIM_W-1:0]                  n_q, n_d, m_q, m_d;
    logic [BW-1:0]                     nb_q, nb_d;
    logic [CNT_W-1:0]                  total_q, total_d, cnt_q, cnt_d;
    logic [RW-1:0]                     row_q, row_d;
    logic [BW-1:0]                     col_q, col_d;
    logic [7:0]                        chk_q, chk_d, byte_q, byte_d;
    logic                              ready_q, ready_d, done_q, done_d;
    logic                              busy_q, busy_d, err_q, err_d;

    logic                              bad_dims;
    logic [DIM_W:0]                    m_round;
    logic [BW-1:0]                     nb_calc;
    logic [MAX_COLS-1:0]               row_bits;
    logic [7:0]                        row_byte, cur_byte;
    logic                              is_chk, is_row;

    // Dimension check and per-row byte count derived from the latched column count.
    always_comb begin
        bad_dims = (n == '0) || (m == '0) || (n > DIM_W'(MAX_ROWS)) || (m > DIM_W'(MAX_COLS));
        m_round  = {1'b0, m_q} + (DIM_W + 1)'(7);
        nb_calc  = BW'(m_round >> 3);
    end

    // Select the byte at the current frame position; columns past m are sent as 0.
    always_comb begin
        row_bits = '0;
        for (int r = 0; r < int'(MAX_ROWS); r++) begin
            if (RW'(r) == row_q) row_bits = sol_q[r];
        end
        row_byte = '0;
        for (int c = 0; c < int'(MAX_COLS); c++) begin
            if ((c / 8) == int'(col_q) && c < int'(m_q)) row_byte[3'(7 - (c % 8))] = row_bits[c];
        end
        is_chk = CHECKSUM_EN && (cnt_q == total_q - CNT_W'(1));
        is_row = (cnt_q >= CNT_W'(3)) && !is_chk;
        if (cnt_q == CNT_W'(0))      cur_byte = HEADER;
        else if (cnt_q == CNT_W'(1)) cur_byte = 8'(n_q);
        else if (cnt_q == CNT_W'(2)) cur_byte = 8'(m_q);
        else if (is_chk)             cur_byte = chk_q;
        else                         cur_byte = row_byte;
    end

    // Frame sequencing: capture, load counters, then send/guard/wait per byte.
    always_comb begin
        state_d = state_q;
        sol_d   = sol_q;
        n_d     = n_q;
        m_d     = m_q;
        nb_d    = nb_q;
        total_d = total_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        col_d   = col_q;
        chk_d   = chk_q;
        byte_d  = byte_q;
        ready_d = 1'b0;
        done_d  = 1'b0;
        busy_d  = busy_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (valid_in) begin
                    sol_d   = solution;
                    // Bad dimensions are framed as a 0x0 grid.
                    n_d     = bad_dims ? '0 : n;
                    m_d     = bad_dims ? '0 : m;
                    err_d   = bad_dims;
                    busy_d  = 1'b1;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                nb_d    = nb_calc;
                total_d = CNT_W'(3 + 32'(CHECKSUM_EN) + int'(n_q) * int'(nb_calc));
                cnt_d   = '0;
                row_d   = '0;
                col_d   = '0;
                chk_d   = '0;
                state_d = StSend;
            end
            StSend: begin
                if (!transmit_busy) begin
                    ready_d = 1'b1;
                    byte_d  = cur_byte;
                    chk_d   = chk_q ^ cur_byte;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (is_row) begin
                        if (col_q == nb_q - BW'(1)) begin
                            col_d = '0;
                            row_d = row_q + RW'(1);
                        end else begin
                            col_d = col_q + BW'(1);
                        end
                    end
                    state_d = StGuard;
                end
            end
            // The UART needs one cycle to raise busy after the strobe.
            StGuard: state_d = StWait;
            StWait: begin
                if (!transmit_busy) begin
                    if (cnt_q == total_q) begin
                        done_d  = 1'b1;
                        state_d = StFin;
                    end else begin
                        state_d = StSend;
                    end
                end
            end
            StFin: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            sol_q   <= '0;
            n_q     <= '0;
            m_q     <= '0;
            nb_q    <= '0;
            total_q <= '0;
            cnt_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            chk_q   <= '0;
            byte_q  <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sol_q   <= sol_d;
            n_q     <= n_d;
            m_q     <= m_d;
            nb_q    <= nb_d;
            total_q <= total_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            chk_q   <= chk_d;
            byte_q  <= byte_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign transmit_ready = ready_q;
    assign byte_out       = byte_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = err_q;

endmodule

// File: tb/tb_solution_serializer.sv
// Bench for solution_serializer: directed table, multi-cycle corner cases and
// randomized frames against a frame-level reference model, with a UART busy model.
module tb_solution_serializer;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid_in;
    logic [15:0][15:0] solution;
    logic [4:0]        n;
    logic [4:0]        m;
    logic              transmit_busy;
    logic              transmit_ready;
    logic [7:0]        byte_out;
    logic              busy;
    logic              done;
    logic              error;

    always #5 clk = ~clk;

    solution_serializer #(
        .MAX_ROWS   (16),
        .MAX_COLS   (16),
        .DIM_W      (5),
        .HEADER     (8'hE0),
        .CHECKSUM_EN(1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_in      (valid_in),
        .solution      (solution),
        .n             (n),
        .m             (m),
        .transmit_busy (transmit_busy),
        .transmit_ready(transmit_ready),
        .byte_out      (byte_out),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    int         checks = 0;
    int         failures = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int         done_total = 0;
    int         busy_cnt = 0;
    bit         force_busy = 1'b0;
    int         d_lo = 0;
    int         d_hi = 0;
    int         start_idx;
    int         done_start;

    assign transmit_busy = force_busy || (busy_cnt != 0);

    // UART model and byte collector: busy for a random number of cycles per strobe.
    always @(negedge clk) begin
        if (transmit_ready) begin
            rx_q.push_back(byte_out);
            busy_cnt <= int'($urandom_range(d_hi, d_lo));
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
        if (done) done_total <= done_total + 1;
    end

    typedef struct {
        int         nn;
        int         mm;
        logic [15:0] rows[4];
        bit         err;
        int         len;
        logic [7:0] b[8];
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference frame computed directly from the framing rules.
    function automatic void build_model(input logic [15:0][15:0] g, input int nn, input int mm);
        bit         bad;
        int         rn, cm, nbytes;
        logic [7:0] bv, x;
        bad = (nn == 0) || (mm == 0) || (nn > 16) || (mm > 16);
        rn = bad ? 0 : nn;
        cm = bad ? 0 : mm;
        nbytes = (cm + 7) / 8;
        exp_q.delete();
        exp_q.push_back(8'hE0);
        exp_q.push_back(8'(rn));
        exp_q.push_back(8'(cm));
        for (int r = 0; r < rn; r++) begin
            for (int b = 0; b < nbytes; b++) begin
                bv = 8'h00;
                for (int k = 0; k < 8; k++) begin
                    if ((8 * b + k) < cm && g[r][8 * b + k]) bv[7 - k] = 1'b1;
                end
                exp_q.push_back(bv);
            end
        end
        x = 8'h00;
        foreach (exp_q[i]) x = x ^ exp_q[i];
        exp_q.push_back(x);
    endfunction

    task automatic start_frame(input logic [15:0][15:0] g, input int nn, input int mm,
                               input string name);
        @(negedge clk);
        start_idx  = rx_q.size();
        done_start = done_total;
        solution   = g;
        n          = 5'(nn);
        m          = 5'(mm);
        valid_in   = 1'b1;
        @(negedge clk);
        valid_in   = 1'b0;
        chk({name, "_busy_set"}, 32'(busy), 32'd1);
    endtask

    task automatic finish_frame(input string name, input bit err_exp);
        int waited = 0;
        while (done_total == done_start && waited < 3000) begin
            @(posedge clk);
            waited++;
        end
        if (done_total == done_start) begin
            chk({name, "_done_timeout"}, 32'd0, 32'd1);
            return;
        end
        @(negedge clk);
        chk({name, "_len"}, 32'(rx_q.size() - start_idx), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (start_idx + i < rx_q.size())
                chk($sformatf("%s_byte%0d", name, i), 32'(rx_q[start_idx + i]), 32'(exp_q[i]));
            else
                chk($sformatf("%s_byte%0d", name, i), 32'h100, 32'(exp_q[i]));
        end
        chk({name, "_error"}, 32'(error), 32'(err_exp));
        chk({name, "_busy_clear"}, 32'(busy), 32'd0);
        chk({name, "_done_count"}, 32'(done_total - done_start), 32'd1);
    endtask

    task automatic wait_bytes(input int cnt, input string name);
        int waited = 0;
        while (rx_q.size() < start_idx + cnt && waited < 2000) begin
            @(posedge clk);
            waited++;
        end
        if (rx_q.size() < start_idx + cnt) chk({name, "_byte_timeout"}, 32'd0, 32'd1);
    endtask

    logic [15:0][15:0] g;
    logic [15:0][15:0] g2;

    initial begin
        int  nn, mm, lat, dref;
        bit  bad;
        rst      = 1'b0;
        valid_in = 1'b0;
        solution = '0;
        n        = '0;
        m        = '0;

        vecs[0].nn = 4;  vecs[0].mm = 4;  vecs[0].err = 0; vecs[0].len = 8;
        vecs[0].rows = '{16'h0009, 16'h0006, 16'h0006, 16'h0009};
        vecs[0].b = '{8'hE0, 8'h04, 8'h04, 8'h90, 8'h60, 8'h60, 8'h90, 8'hE0};
        vecs[1].nn = 2;  vecs[1].mm = 11; vecs[1].err = 0; vecs[1].len = 8;
        vecs[1].rows = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000};
        vecs[1].b = '{8'hE0, 8'h02, 8'h0B, 8'hFF, 8'hE0, 8'hFF, 8'hE0, 8'hE9};
        vecs[2].nn = 0;  vecs[2].mm = 4;  vecs[2].err = 1; vecs[2].len = 4;
        vecs[2].rows = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        vecs[2].b = '{8'hE0, 8'h00, 8'h00, 8'hE0, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[3].nn = 1;  vecs[3].mm = 1;  vecs[3].err = 0; vecs[3].len = 5;
        vecs[3].rows = '{16'h0001, 16'h0000, 16'h0000, 16'h0000};
        vecs[3].b = '{8'hE0, 8'h01, 8'h01, 8'h80, 8'h60, 8'h00, 8'h00, 8'h00};
        vecs[4].nn = 17; vecs[4].mm = 3;  vecs[4].err = 1; vecs[4].len = 4;
        vecs[4].rows = '{16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF};
        vecs[4].b = '{8'hE0, 8'h00, 8'h00, 8'hE0, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[5].nn = 1;  vecs[5].mm = 9;  vecs[5].err = 0; vecs[5].len = 6;
        vecs[5].rows = '{16'h0101, 16'h0000, 16'h0000, 16'h0000};
        vecs[5].b = '{8'hE0, 8'h01, 8'h09, 8'h80, 8'h80, 8'hE8, 8'h00, 8'h00};
        vecs[6].nn = 3;  vecs[6].mm = 0;  vecs[6].err = 1; vecs[6].len = 4;
        vecs[6].rows = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
        vecs[6].b = '{8'hE0, 8'h00, 8'h00, 8'hE0, 8'h00, 8'h00, 8'h00, 8'h00};

        repeat (3) @(negedge clk);
        chk("reset_outputs", {27'd0, transmit_ready, busy, done, error, |byte_out}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Directed table; busy idle on the even entries, slow UART on the odd ones.
        for (int v = 0; v < 7; v++) begin
            d_lo = (v % 2 == 0) ? 0 : 1;
            d_hi = (v % 2 == 0) ? 0 : 3;
            g = '0;
            for (int r = 0; r < 4; r++) g[r] = vecs[v].rows[r];
            exp_q.delete();
            for (int i = 0; i < vecs[v].len; i++) exp_q.push_back(vecs[v].b[i]);
            start_frame(g, vecs[v].nn, vecs[v].mm, $sformatf("vec%0d", v));
            finish_frame($sformatf("vec%0d", v), vecs[v].err);
            if (vecs[v].err) begin
                repeat (8) @(negedge clk);
                chk($sformatf("vec%0d_error_sticky", v), 32'(error), 32'd1);
            end
        end

        // First strobe three cycles after valid_in with an idle UART.
        d_lo = 0; d_hi = 0;
        g = '0; g[0] = 16'h0003; g[1] = 16'h0002;
        build_model(g, 2, 2);
        start_frame(g, 2, 2, "latency");
        lat = 1;
        while (!transmit_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency_first_strobe", 32'(lat), 32'd3);
        finish_frame("latency", 1'b0);

        // UART busy held for 50 cycles before the first byte.
        d_lo = 1; d_hi = 2;
        for (int r = 0; r < 16; r++) g[r] = 16'($urandom);
        build_model(g, 5, 13);
        force_busy = 1'b1;
        start_frame(g, 5, 13, "hold");
        repeat (50) @(negedge clk);
        chk("hold_no_strobe", 32'(rx_q.size() - start_idx), 32'd0);
        force_busy = 1'b0;
        finish_frame("hold", 1'b0);

        // valid_in mid-frame with a different grid is ignored.
        d_lo = 0; d_hi = 2;
        for (int r = 0; r < 16; r++) g[r] = 16'($urandom);
        for (int r = 0; r < 16; r++) g2[r] = 16'($urandom);
        build_model(g, 6, 16);
        start_frame(g, 6, 16, "midvalid");
        wait_bytes(4, "midvalid");
        @(negedge clk);
        solution = g2; n = 5'd3; m = 5'd0; valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        finish_frame("midvalid", 1'b0);

        // Reset after the third byte aborts the frame without done.
        d_lo = 2; d_hi = 2;
        build_model(g, 8, 16);
        start_frame(g, 8, 16, "abort");
        wait_bytes(3, "abort");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_outputs_zero", {27'd0, transmit_ready, busy, done, error, |byte_out}, 32'd0);
        rst = 1'b1;
        dref = done_total;
        repeat (30) @(negedge clk);
        chk("abort_no_done", 32'(done_total - dref), 32'd0);
        chk("abort_idle", 32'(busy), 32'd0);
        d_lo = 0; d_hi = 1;
        build_model(g, 3, 7);
        start_frame(g, 3, 7, "after_abort");
        finish_frame("after_abort", 1'b0);

        // Randomized frames against the reference model.
        for (int t = 0; t < 25; t++) begin
            for (int r = 0; r < 16; r++) g[r] = 16'($urandom);
            nn = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(31, 17)))
                                               : int'($urandom_range(16, 1));
            mm = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(31, 17)))
                                               : int'($urandom_range(16, 1));
            bad = (nn == 0) || (mm == 0) || (nn > 16) || (mm > 16);
            d_lo = 0;
            d_hi = int'($urandom_range(3, 0));
            build_model(g, nn, mm);
            start_frame(g, nn, mm, $sformatf("rand%0d", t));
            finish_frame($sformatf("rand%0d", t), bad);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
